uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises a complete asynchronous frame: start bit, NrOfDataBits data bits (LSB first), optional even/odd parity, and 1 or 2 stop bits. A valid/ready handshake accepts one word per frame. Back-to-back frames are sent with no idle gap. Successor to the single-bit/data-bit transmitter chain; intended as the sole TX path feeding the board UART pin.

Parameters:
ClockFrequency, 1000000, clock frequency in Hz.
BaudRate, 9600, line rate in baud. Bit period BitClocks = ClockFrequency/BaudRate (integer division, must be >= 2).
NrOfDataBits, 8, data bits per frame; legal range 5..9.
ParityMode, 0, 0 = none, 1 = even, 2 = odd.
NrOfStopBits, 1, stop bits per frame; legal values 1 or 2.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
dataValid  input  1  word on dataBits is offered for transmission.
dataBits  input  NrOfDataBits  word to send; sampled only at acceptance.
dataReady  output  1  block can accept a word this cycle.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse at the end of the final stop bit.
tx  output  1  serial line; idle high.

Behaviour:
- Reset asserted (low): tx=1, dataReady=0, busy=0, done=0 immediately. The state machine goes to IDLE and the bit/baud counters clear. The first rising clock edge after reset release sets dataReady=1.
- Reset mid-frame aborts the frame. tx returns high asynchronously and no done pulse is generated.
- Acceptance: a rising edge where dataValid=1 and dataReady=1.
  - dataBits is latched into a shift register.
  - Parity is computed from the latched word: even = XOR of all bits; odd = its inverse.
  - dataReady drops and busy rises.
  - tx goes low (start bit) starting the cycle after the acceptance edge, i.e. one clock of latency.
- dataBits/dataValid changes while busy are ignored; the latched word is sent unchanged.
- State machine: IDLE -> START -> DATA -> PARITY (skipped when ParityMode=0) -> STOP -> IDLE or START.
- Each state/bit lasts exactly BitClocks clocks, timed by a baud counter that reloads on every bit boundary.
- DATA shifts LSB first; a bit index runs from 0 to NrOfDataBits-1.
- STOP drives tx=1 for NrOfStopBits*BitClocks clocks.
- Frame length = (1 + NrOfDataBits + (ParityMode!=0) + NrOfStopBits) * BitClocks clocks.
- End of frame, last stop-bit clock:
  - done=1 for exactly that cycle and dataReady=1 in that same cycle.
  - If dataValid=1 in that cycle, the new word is accepted and its start bit begins the next cycle. busy stays high with no idle gap.
  - Otherwise the block enters IDLE, busy=0 and tx=1.
- dataReady is never high while busy is high, except in the done cycle.
- ParityMode values 3 and up behave as none. Out-of-range parameters are not supported and need no checking.
- tx is a registered output; no combinational path from any input to tx except reset.

Test Plan:
- Reset/idle: hold reset low for 5 cycles, release, dataValid=0 for 50 cycles -> tx=1, busy=0, done=0 throughout; dataReady=1 from the first edge after release.
- 8N1 frame (ClockFrequency=1000000, BaudRate=100000, BitClocks=10): send 0xA5 -> tx per 10-clock slot = 0,1,0,1,0,0,1,0,1,1. busy high for 100 clocks, done pulses on clock 100 after acceptance, tx low one cycle after acceptance.
- Parity: 0xA5 with ParityMode=1 -> parity slot 0. With ParityMode=2 -> parity slot 1. With ParityMode=2 and word 0x01 -> parity slot 0. Frame length 110 clocks.
- Two stop bits with back-to-back handshake: NrOfStopBits=2, dataValid held high with 0x00 then 0xFF. Required:
  - stop slot is 20 clocks;
  - second word accepted in the done cycle;
  - second start bit begins the next clock, with no idle clock between frames.
- Handshake robustness: change dataBits from 0x3C to 0xC3 and toggle dataValid mid-frame -> transmitted bits match 0x3C, dataReady stays 0 until the done cycle.
- Reset mid-frame: assert reset during data bit 3 -> tx=1 immediately, no done pulse. A new word after release is sent correctly from its start bit.
- Width sweep: NrOfDataBits=5 and 9 with ParityMode=1 -> correct bit count, LSB-first order and parity.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Valid/ready handshake; a word offered in the done cycle starts the next frame with no gap.
module uart_tx_frame #(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned BaudRate       = 9600,
  parameter int unsigned NrOfDataBits   = 8,
  parameter int unsigned ParityMode     = 0,
  parameter int unsigned NrOfStopBits   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dataValid,
  input  logic [NrOfDataBits-1:0] dataBits,
  output logic                    dataReady,
  output logic                    busy,
  output logic                    done,
  output logic                    tx
);

  localparam int unsigned BitClocks  = ClockFrequency / BaudRate;
  localparam int unsigned StopClocks = NrOfStopBits * BitClocks;
  localparam int unsigned CntW       = $clog2(StopClocks);
  localparam int unsigned IdxW       = $clog2(NrOfDataBits);
  localparam bit          ParityEn   = (ParityMode == 1) || (ParityMode == 2);
  localparam bit          ParityOdd  = (ParityMode == 2);

  localparam logic [CntW-1:0] BitLoad  = CntW'(BitClocks - 1);
  localparam logic [CntW-1:0] StopLoad = CntW'(StopClocks - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NrOfDataBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NrOfDataBits-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    accept;
  logic                    launch;

  assign accept = dataValid & ready_q;

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they leave registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = 1'b0;
    launch  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        launch  = accept;
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = BitLoad;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BitLoad;
          if (idx_q == LastIdx) begin
            if (ParityEn) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
              cnt_d   = StopLoad;
            end
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = StopLoad;
        end
      end
      STOP: begin
        // The cycle before the last stop clock arms done and ready for the final clock.
        if (cnt_q == CntW'(1)) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
        if (cnt_q == '0) begin
          if (accept) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (launch) begin
      state_d = START;
      cnt_d   = BitLoad;
      shift_d = dataBits;
      par_d   = ParityOdd ? ~(^dataBits) : ^dataBits;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dataReady = ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: six parameter variants checked against a slot-based frame model.
module tb_uart_tx_frame;

  localparam int BC = 10;
  localparam int ND = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [ND-1:0] dv = '0;
  logic [ND-1:0] rdy, bsy, dn, txs;
  logic [8:0]    db [ND];

  int nb [ND] = '{8, 8, 8, 8, 5, 9};
  int pm [ND] = '{0, 1, 2, 0, 1, 1};
  int ns [ND] = '{1, 1, 1, 2, 1, 1};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .NrOfDataBits(8), .ParityMode(0), .NrOfStopBits(1)) u0 (
    .clock(clock), .reset(reset), .dataValid(dv[0]), .dataBits(db[0][7:0]),
    .dataReady(rdy[0]), .busy(bsy[0]), .done(dn[0]), .tx(txs[0]));
  uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .NrOfDataBits(8), .ParityMode(1), .NrOfStopBits(1)) u1 (
    .clock(clock), .reset(reset), .dataValid(dv[1]), .dataBits(db[1][7:0]),
    .dataReady(rdy[1]), .busy(bsy[1]), .done(dn[1]), .tx(txs[1]));
  uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .NrOfDataBits(8), .ParityMode(2), .NrOfStopBits(1)) u2 (
    .clock(clock), .reset(reset), .dataValid(dv[2]), .dataBits(db[2][7:0]),
    .dataReady(rdy[2]), .busy(bsy[2]), .done(dn[2]), .tx(txs[2]));
  uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .NrOfDataBits(8), .ParityMode(0), .NrOfStopBits(2)) u3 (
    .clock(clock), .reset(reset), .dataValid(dv[3]), .dataBits(db[3][7:0]),
    .dataReady(rdy[3]), .busy(bsy[3]), .done(dn[3]), .tx(txs[3]));
  uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .NrOfDataBits(5), .ParityMode(1), .NrOfStopBits(1)) u4 (
    .clock(clock), .reset(reset), .dataValid(dv[4]), .dataBits(db[4][4:0]),
    .dataReady(rdy[4]), .busy(bsy[4]), .done(dn[4]), .tx(txs[4]));
  uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .NrOfDataBits(9), .ParityMode(1), .NrOfStopBits(1)) u5 (
    .clock(clock), .reset(reset), .dataValid(dv[5]), .dataBits(db[5][8:0]),
    .dataReady(rdy[5]), .busy(bsy[5]), .done(dn[5]), .tx(txs[5]));

  function automatic bit has_par(int k);
    return (pm[k] == 1) || (pm[k] == 2);
  endfunction

  function automatic int flen(int k);
    return (1 + nb[k] + (has_par(k) ? 1 : 0) + ns[k]) * BC;
  endfunction

  function automatic logic [8:0] rand_word(int k);
    logic [8:0] r;
    r = 9'($urandom);
    return r & 9'((1 << nb[k]) - 1);
  endfunction

  // Expected line level in clock c (1-based, counted from the acceptance edge).
  function automatic logic exp_tx(int k, logic [8:0] w, int c);
    int slot;
    int ones;
    slot = (c - 1) / BC;
    ones = 0;
    if (slot == 0) return 1'b0;
    if (slot <= nb[k]) return w[slot-1];
    if (has_par(k) && slot == nb[k] + 1) begin
      for (int i = 0; i < nb[k]; i++) ones += int'(w[i]);
      return (pm[k] == 1) ? 1'(ones % 2) : 1'((ones + 1) % 2);
    end
    return 1'b1;
  endfunction

  // Sends one word on DUT k and checks every clock of its frame.
  // mode 0: inputs quiet; 1: dataValid/dataBits scrambled mid-frame; 2: next word w2 offered for chaining.
  // chained: the word was already taken at the previous done edge.
  task automatic frame(input int k, input logic [8:0] w, input int mode, input logic [8:0] w2,
                       input bit chained, input string tag);
    int f;
    int guard;
    logic et;
    f = flen(k);
    guard = 0;
    if (!chained) begin
      db[k] = w;
      dv[k] = 1'b1;
      while (rdy[k] !== 1'b1 && guard < 200) begin
        @(negedge clock);
        guard++;
      end
      n_cmp++;
      if (rdy[k] !== 1'b1) begin
        n_err++;
        $display("FAIL %s accept_timeout k=%0d dataReady=%b required 1", tag, k, rdy[k]);
        dv[k] = 1'b0;
        return;
      end
      @(posedge clock);
    end
    for (int c = 1; c <= f; c++) begin
      @(negedge clock);
      et = exp_tx(k, w, c);
      n_cmp += 4;
      if (txs[k] !== et) begin
        n_err++;
        $display("FAIL %s tx k=%0d clk=%0d got %b required %b", tag, k, c, txs[k], et);
      end
      if (bsy[k] !== 1'b1) begin
        n_err++;
        $display("FAIL %s busy k=%0d clk=%0d got %b required 1", tag, k, c, bsy[k]);
      end
      if (dn[k] !== 1'(c == f)) begin
        n_err++;
        $display("FAIL %s done k=%0d clk=%0d got %b required %b", tag, k, c, dn[k], c == f);
      end
      if (rdy[k] !== 1'(c == f)) begin
        n_err++;
        $display("FAIL %s dataReady k=%0d clk=%0d got %b required %b", tag, k, c, rdy[k], c == f);
      end
      case (mode)
        1: begin
          if (c < f) begin
            dv[k] = 1'($urandom_range(0, 1));
            db[k] = 9'($urandom);
          end else begin
            dv[k] = 1'b0;
          end
        end
        2: begin
          dv[k] = 1'b1;
          db[k] = w2;
        end
        default: dv[k] = 1'b0;
      endcase
    end
    if (mode != 2) begin
      @(negedge clock);
      n_cmp += 4;
      if (txs[k] !== 1'b1) begin
        n_err++;
        $display("FAIL %s idle_tx k=%0d got %b required 1", tag, k, txs[k]);
      end
      if (bsy[k] !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_busy k=%0d got %b required 0", tag, k, bsy[k]);
      end
      if (dn[k] !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_done k=%0d got %b required 0", tag, k, dn[k]);
      end
      if (rdy[k] !== 1'b1) begin
        n_err++;
        $display("FAIL %s idle_ready k=%0d got %b required 1", tag, k, rdy[k]);
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp += 4;
      if (txs !== '1) begin n_err++; $display("FAIL rst_tx got %b required all 1", txs); end
      if (bsy !== '0) begin n_err++; $display("FAIL rst_busy got %b required 0", bsy); end
      if (dn !== '0) begin n_err++; $display("FAIL rst_done got %b required 0", dn); end
      if (rdy !== '0) begin n_err++; $display("FAIL rst_ready got %b required 0", rdy); end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rdy !== '0) begin n_err++; $display("FAIL rel_ready_early got %b required 0", rdy); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      n_cmp += 4;
      if (txs !== '1) begin n_err++; $display("FAIL idle_tx cyc=%0d got %b required all 1", i, txs); end
      if (bsy !== '0) begin n_err++; $display("FAIL idle_busy cyc=%0d got %b required 0", i, bsy); end
      if (dn !== '0) begin n_err++; $display("FAIL idle_done cyc=%0d got %b required 0", i, dn); end
      if (rdy !== '1) begin n_err++; $display("FAIL idle_ready cyc=%0d got %b required all 1", i, rdy); end
    end
  endtask

  task automatic test_frame_8n1();
    frame(0, 9'h0A5, 0, 9'h0, 1'b0, "8n1_a5");
    for (int i = 0; i < 3; i++) frame(0, rand_word(0), 0, 9'h0, 1'b0, "8n1_rand");
  endtask

  task automatic test_parity();
    frame(1, 9'h0A5, 0, 9'h0, 1'b0, "even_a5");
    frame(2, 9'h0A5, 0, 9'h0, 1'b0, "odd_a5");
    frame(2, 9'h001, 0, 9'h0, 1'b0, "odd_01");
    for (int i = 0; i < 2; i++) begin
      frame(1, rand_word(1), 0, 9'h0, 1'b0, "even_rand");
      frame(2, rand_word(2), 0, 9'h0, 1'b0, "odd_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] a;
    logic [8:0] b;
    frame(3, 9'h000, 2, 9'h0FF, 1'b0, "b2b_00");
    frame(3, 9'h0FF, 0, 9'h0, 1'b1, "b2b_ff");
    a = rand_word(1);
    b = rand_word(1);
    frame(1, a, 2, b, 1'b0, "b2b_even_a");
    frame(1, b, 0, 9'h0, 1'b1, "b2b_even_b");
  endtask

  task automatic test_handshake();
    frame(0, 9'h03C, 1, 9'h0, 1'b0, "hs_3c");
    frame(5, rand_word(5), 1, 9'h0, 1'b0, "hs_9bit");
  endtask

  task automatic test_reset_midframe();
    int guard;
    guard = 0;
    db[0] = 9'h05A;
    dv[0] = 1'b1;
    while (rdy[0] !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_accept_timeout dataReady=%b required 1", rdy[0]);
    end
    @(posedge clock);
    dv[0] = 1'b0;
    repeat (45) @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp += 3;
    if (txs[0] !== 1'b1) begin n_err++; $display("FAIL midrst_tx got %b required 1", txs[0]); end
    if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b required 0", bsy[0]); end
    if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b required 0", rdy[0]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dn[0] !== 1'b0) begin n_err++; $display("FAIL midrst_done cyc=%0d got %b required 0", i, dn[0]); end
    end
    reset = 1'b1;
    frame(0, rand_word(0), 0, 9'h0, 1'b0, "after_rst");
  endtask

  task automatic test_width_sweep();
    frame(4, 9'h015, 0, 9'h0, 1'b0, "w5_15");
    frame(5, 9'h1A5, 0, 9'h0, 1'b0, "w9_1a5");
    for (int i = 0; i < 3; i++) begin
      frame(4, rand_word(4), 0, 9'h0, 1'b0, "w5_rand");
      frame(5, rand_word(5), 0, 9'h0, 1'b0, "w9_rand");
    end
  endtask

  initial begin
    for (int i = 0; i < ND; i++) db[i] = 9'h0;
    test_reset();
    test_frame_8n1();
    test_parity();
    test_back_to_back();
    test_handshake();
    test_reset_midframe();
    test_width_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
